// File: rtl/rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer and related system-control blocks.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 1048576;
  localparam int unsigned DEF_STAGE_GAP_CYCLES    = 256;
  localparam int unsigned DEF_NUM_STAGES          = 3;
  localparam int unsigned DEF_SYNC_STAGES         = 2;

  localparam int unsigned EVT_W = 8;

  // Saturating increment for event counters.
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == '1) ? v : v + EVT_W'(1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock-qualified, staged reset release for downstream domains; retries the PLL
// on lock timeout and re-asserts all resets on loss of lock or soft reset.
module pll_reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned NUM_STAGES          = DEF_NUM_STAGES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_ready,
  output logic [EVT_W-1:0]      timeout_cnt,
  output logic [EVT_W-1:0]      lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > STAGE_GAP_CYCLES) ? LOCK_TIMEOUT_CYCLES : STAGE_GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic                  locked_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_ready_q, sys_ready_d;
  logic [EVT_W-1:0]      timeout_q, timeout_d;
  logic [EVT_W-1:0]      loss_q, loss_d;
  logic                  lock_lost;
  logic                  soft_abort;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Next-state and registered-output logic; aborts take priority over all progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    stage_d     = stage_q;
    timeout_d   = timeout_q;
    loss_d      = loss_q;
    sys_ready_d = 1'b0;

    lock_lost  = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !locked_s;
    soft_abort = (state_q != ST_PLL_RST) && soft_reset_req;

    if (lock_lost || soft_abort) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      stage_d = '0;
      if (lock_lost) loss_d = sat_inc(loss_q);
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_PLL_RST;
            cnt_d     = '0;
            timeout_d = sat_inc(timeout_q);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            cnt_d   = '0;
            stage_d = NUM_STAGES'(1);
            state_d = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
            cnt_d   = '0;
            stage_d = (stage_q << 1) | NUM_STAGES'(1);
            if (stage_d[NUM_STAGES-1]) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_d       = cnt_q;
          sys_ready_d = 1'b1;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          stage_d = '0;
        end
      endcase
    end

    pll_rst_d = (state_d == ST_PLL_RST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      stage_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      timeout_q   <= '0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      pll_rst_q   <= pll_rst_d;
      sys_ready_q <= sys_ready_d;
      timeout_q   <= timeout_d;
      loss_q      <= loss_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign stage_rst_n   = stage_q;
  assign sys_ready     = sys_ready_q;
  assign timeout_cnt   = timeout_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; cycle numbers count from the first
// cycle with rst low (cycle 1), sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic [2:0] stage_rst_n;
  logic       sys_ready;
  logic [7:0] timeout_cnt;
  logic [7:0] lock_loss_cnt;

  int n_assert;
  int n_fail;
  int cyc;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (50),
    .STAGE_GAP_CYCLES    (5),
    .NUM_STAGES          (3),
    .SYNC_STAGES         (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .stage_rst_n    (stage_rst_n),
    .sys_ready      (sys_ready),
    .timeout_cnt    (timeout_cnt),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 1;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    cyc            = 0;
    rst            = 1'b1;
    pll_locked     = 1'b1;
    soft_reset_req = 1'b0;

    // Clean start
    do_reset();
    chk("rst_pll_rst", 32'(pll_rst), 32'(1'b1));
    chk("rst_stage", 32'(stage_rst_n), 32'(3'b000));
    chk("rst_ready", 32'(sys_ready), 32'(1'b0));
    chk("rst_tmo", 32'(timeout_cnt), 32'(8'd0));
    chk("rst_loss", 32'(lock_loss_cnt), 32'(8'd0));
    run_to(4);  chk("clean_pllrst_c4", 32'(pll_rst), 32'(1'b1));
    run_to(5);  chk("clean_pllrst_c5", 32'(pll_rst), 32'(1'b0));
    run_to(13); chk("clean_stage_c13", 32'(stage_rst_n), 32'(3'b000));
    run_to(14); chk("clean_stage_c14", 32'(stage_rst_n), 32'(3'b001));
    run_to(18); chk("clean_stage_c18", 32'(stage_rst_n), 32'(3'b001));
    run_to(19); chk("clean_stage_c19", 32'(stage_rst_n), 32'(3'b011));
    run_to(23); chk("clean_stage_c23", 32'(stage_rst_n), 32'(3'b011));
    run_to(24); chk("clean_stage_c24", 32'(stage_rst_n), 32'(3'b111));
                chk("clean_ready_c24", 32'(sys_ready), 32'(1'b0));
    run_to(25); chk("clean_ready_c25", 32'(sys_ready), 32'(1'b1));

    // Lock loss in RUN
    run_to(40); pll_locked = 1'b0;
    run_to(42); chk("loss_stage_c42", 32'(stage_rst_n), 32'(3'b111));
                chk("loss_ready_c42", 32'(sys_ready), 32'(1'b1));
    run_to(43); chk("loss_stage_c43", 32'(stage_rst_n), 32'(3'b000));
                chk("loss_ready_c43", 32'(sys_ready), 32'(1'b0));
                chk("loss_cnt_c43", 32'(lock_loss_cnt), 32'(8'd1));
                chk("loss_pllrst_c43", 32'(pll_rst), 32'(1'b1));
    run_to(44); pll_locked = 1'b1;
    run_to(46); chk("loss_pllrst_c46", 32'(pll_rst), 32'(1'b1));
    run_to(47); chk("loss_pllrst_c47", 32'(pll_rst), 32'(1'b0));
    run_to(55); chk("rerun_stage_c55", 32'(stage_rst_n), 32'(3'b000));
    run_to(56); chk("rerun_stage_c56", 32'(stage_rst_n), 32'(3'b001));
    run_to(66); chk("rerun_stage_c66", 32'(stage_rst_n), 32'(3'b111));
    run_to(67); chk("rerun_ready_c67", 32'(sys_ready), 32'(1'b1));
                chk("rerun_loss_c67", 32'(lock_loss_cnt), 32'(8'd1));

    // Soft reset in RUN
    run_to(70); soft_reset_req = 1'b1;
    tick();     soft_reset_req = 1'b0;
    chk("soft_stage_c71", 32'(stage_rst_n), 32'(3'b000));
    chk("soft_ready_c71", 32'(sys_ready), 32'(1'b0));
    chk("soft_pllrst_c71", 32'(pll_rst), 32'(1'b1));
    chk("soft_loss_c71", 32'(lock_loss_cnt), 32'(8'd1));
    run_to(74); chk("soft_pllrst_c74", 32'(pll_rst), 32'(1'b1));
    run_to(75); chk("soft_pllrst_c75", 32'(pll_rst), 32'(1'b0));
    run_to(83); chk("soft_stage_c83", 32'(stage_rst_n), 32'(3'b000));
    run_to(84); chk("soft_stage_c84", 32'(stage_rst_n), 32'(3'b001));
    run_to(89); chk("soft_stage_c89", 32'(stage_rst_n), 32'(3'b011));
                chk("soft_loss_c89", 32'(lock_loss_cnt), 32'(8'd1));

    // rst pulse during RELEASE
    run_to(90); rst = 1'b1;
    tick();
    chk("midrst_pllrst", 32'(pll_rst), 32'(1'b1));
    chk("midrst_stage", 32'(stage_rst_n), 32'(3'b000));
    chk("midrst_ready", 32'(sys_ready), 32'(1'b0));
    chk("midrst_loss", 32'(lock_loss_cnt), 32'(8'd0));
    chk("midrst_tmo", 32'(timeout_cnt), 32'(8'd0));
    rst = 1'b0;
    cyc = 1;

    // Glitch in STABLE: locked_s low only in cycle 9
    run_to(7);  pll_locked = 1'b0;
    run_to(8);  pll_locked = 1'b1;
    run_to(14); chk("glitch_stage_c14", 32'(stage_rst_n), 32'(3'b000));
    run_to(18); chk("glitch_stage_c18", 32'(stage_rst_n), 32'(3'b000));
    run_to(19); chk("glitch_stage_c19", 32'(stage_rst_n), 32'(3'b001));
    run_to(29); chk("glitch_stage_c29", 32'(stage_rst_n), 32'(3'b111));
    run_to(30); chk("glitch_ready_c30", 32'(sys_ready), 32'(1'b1));
                chk("glitch_loss_c30", 32'(lock_loss_cnt), 32'(8'd0));

    // Lock loss in the cycle stage 1 would release
    do_reset();
    run_to(16); pll_locked = 1'b0;
    run_to(18); chk("midrel_stage_c18", 32'(stage_rst_n), 32'(3'b001));
    run_to(19); chk("midrel_stage_c19", 32'(stage_rst_n), 32'(3'b000));
                chk("midrel_loss_c19", 32'(lock_loss_cnt), 32'(8'd1));
                chk("midrel_pllrst_c19", 32'(pll_rst), 32'(1'b1));
    run_to(24); chk("midrel_stage_c24", 32'(stage_rst_n), 32'(3'b000));

    // Timeout retry with saturation
    pll_locked = 1'b0;
    do_reset();
    run_to(54);    chk("tmo_pllrst_c54", 32'(pll_rst), 32'(1'b0));
                   chk("tmo_cnt_c54", 32'(timeout_cnt), 32'(8'd0));
    run_to(55);    chk("tmo_pllrst_c55", 32'(pll_rst), 32'(1'b1));
                   chk("tmo_cnt_c55", 32'(timeout_cnt), 32'(8'd1));
                   chk("tmo_stage_c55", 32'(stage_rst_n), 32'(3'b000));
    run_to(58);    chk("tmo_pllrst_c58", 32'(pll_rst), 32'(1'b1));
    run_to(59);    chk("tmo_pllrst_c59", 32'(pll_rst), 32'(1'b0));
    run_to(109);   chk("tmo_cnt_c109", 32'(timeout_cnt), 32'(8'd2));
    run_to(13770); chk("tmo_cnt_254", 32'(timeout_cnt), 32'(8'd254));
    run_to(13771); chk("tmo_cnt_255", 32'(timeout_cnt), 32'(8'd255));
    run_to(13826); chk("tmo_cnt_sat", 32'(timeout_cnt), 32'(8'd255));
                   chk("tmo_pllrst_sat", 32'(pll_rst), 32'(1'b1));
                   chk("tmo_stage_sat", 32'(stage_rst_n), 32'(3'b000));

    // Event counters clear only on rst
    do_reset();
    chk("final_tmo_clear", 32'(timeout_cnt), 32'(8'd0));
    chk("final_loss_clear", 32'(lock_loss_cnt), 32'(8'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the PLL `LOCKED` indication that the clock-generation wrapper produces, and turns it into an orderly, lock-qualified reset release for downstream domains (DDR controller, camera interface, video pipeline). Drives the PLL's reset, retries the PLL on lock timeout, and re-asserts all downstream resets on loss of lock. Sits beside the clock/PLL wrapper in the top-level system control and runs on the free-running 100 MHz input clock.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset attempt (≥1)
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1)
- `LOCK_TIMEOUT_CYCLES`, 1048576: cycles allowed in WAIT_LOCK before a PLL retry (≥1)
- `STAGE_GAP_CYCLES`, 256: cycles between successive stage releases (≥1)
- `NUM_STAGES`, 3: number of downstream reset outputs (1..8)
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2)

Ports:
- `clk` in 1: free-running 100 MHz reference clock
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: PLL lock, asynchronous to `clk`
- `soft_reset_req` in 1: single-cycle request to re-run the full sequence
- `pll_rst` out 1: active-high reset to the PLL
- `stage_rst_n` out NUM_STAGES: active-low downstream resets, bit 0 released first
- `sys_ready` out 1: high while all stages are released and lock is held
- `timeout_cnt` out 8: saturating count of lock-timeout retries
- `lock_loss_cnt` out 8: saturating count of lock losses after release

## Operation
- `pll_locked` passes through a SYNC_STAGES flop chain to produce `locked_s`. All decisions use `locked_s` only.
- FSM states:
  - **PLL_RST**: `pll_rst`=1 for PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0 and the timeout counter runs.
    - If `locked_s`=1, go to STABLE.
    - If the counter reaches LOCK_TIMEOUT_CYCLES, increment `timeout_cnt` and go to PLL_RST.
  - **STABLE**: counts consecutive `locked_s`=1 cycles.
    - Any 0 returns to WAIT_LOCK with the timeout counter cleared.
    - When the count reaches LOCK_STABLE_CYCLES, go to RELEASE.
  - **RELEASE**: on entry, `stage_rst_n[0]`=1. Each further bit k rises STAGE_GAP_CYCLES after bit k−1. The cycle bit NUM_STAGES−1 rises, go to RUN.
  - **RUN**: `sys_ready`=1 from the cycle after entry.
- Lock loss: `locked_s`=0 in RELEASE or RUN. On the next edge, all `stage_rst_n`=0, `sys_ready`=0, `lock_loss_cnt` increments, and the FSM goes to PLL_RST.
- `soft_reset_req` in any state other than PLL_RST behaves as lock loss, except that `lock_loss_cnt` does not increment. It is ignored in PLL_RST.
- Outside RELEASE/RUN, `stage_rst_n` is all zeros.
- Counters are sized `$clog2(param+1)`. Event counters saturate at 255 and clear only on `rst`.

## Timing
- Reset values:
  - `pll_rst`=1, `stage_rst_n`=0, `sys_ready`=0
  - `timeout_cnt`=0, `lock_loss_cnt`=0
  - state=PLL_RST, synchronizer flops=0
- The first cycle with `rst`=0 is PLL_RST cycle 1.
- `pll_locked` reaches `locked_s` after SYNC_STAGES edges.
- All outputs are registered. There is no combinational path from input to output.
- Simultaneous events:
  - Lock loss wins over a stage release in the same cycle.
  - Lock loss or soft reset wins over a STABLE→RELEASE transition.
  - Timeout and lock detection in the same WAIT_LOCK cycle: lock wins.
- `rst` mid-sequence: all outputs return to their reset values on the next edge.

## Structure
- Shared package `rst_seq_pkg` holds:
  - FSM state encodings (PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN)
  - default cycle constants
  - event-counter width (8)
- Sub-module `bit_sync` is the parameterized SYNC_STAGES flop chain, reused for other asynchronous status bits.

## Test plan
All scenarios use PLL_RST=4, STABLE=8, TIMEOUT=50, GAP=5, STAGES=3, SYNC=2.

- **Clean start.** `pll_locked`=1 from reset.
  - `pll_rst` high cycles 1–4.
  - WAIT_LOCK at cycle 5, STABLE cycles 6–13.
  - `stage_rst_n` = 001 at cycle 14, 011 at 19, 111 at 24.
  - `sys_ready`=1 at cycle 25.
- **Timeout retry.** `pll_locked`=0 throughout.
  - `pll_rst` re-pulses for 4 cycles after every 50 WAIT_LOCK cycles.
  - `timeout_cnt` increments per retry and saturates at 255.
  - `stage_rst_n` stays 000.
- **Glitch in STABLE.** `pll_locked` low for 1 cycle midway through STABLE.
  - FSM returns to WAIT_LOCK, then STABLE restarts a full 8-cycle count.
  - Release is delayed accordingly and `lock_loss_cnt` stays 0.
- **Lock loss in RUN.** Drop `pll_locked` at cycle 40.
  - `stage_rst_n`=000 and `sys_ready`=0 by cycle 43 (2 sync + 1 register).
  - `lock_loss_cnt`=1 and `pll_rst`=1 for 4 cycles.
  - Full sequence re-runs.
- **Lock loss mid-release.** Drop lock in the cycle stage 1 would release.
  - Stage 1 never rises and all bits clear.
- **Soft reset and `rst` mid-sequence.** `soft_reset_req` in RUN, then `rst` pulse during RELEASE.
  - Soft reset: sequence re-runs with `lock_loss_cnt` unchanged.
  - `rst`: all outputs and counters at reset values on the next edge.
